mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 25 ++
 rtl/mem_access_unit_load_extender.sv | 20 ++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the byte-serial memory access unit: FSM states,
// access-size codes and the beat-count helper.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } ma_state_e;

  localparam logic [1:0] TRUNK_WORD = 2'b00;
  localparam logic [1:0] TRUNK_HALF = 2'b01;
  localparam logic [1:0] TRUNK_BYTE = 2'b10;

  // Index of the final beat (N-1); code 11 is treated as a word access.
  function automatic logic [1:0] last_beat(input logic [1:0] trunk);
    case (trunk)
      TRUNK_HALF: return 2'd1;
      TRUNK_BYTE: return 2'd0;
      default:    return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Sign/zero extension of an assembled load value according to access size.
module load_extender
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [1:0]  trunk,
  input  logic        is_signed,
  output logic [31:0] result
);

  always_comb begin
    result = acc;
    case (trunk)
      TRUNK_BYTE: result = {{24{is_signed & acc[7]}}, acc[7:0]};
      TRUNK_HALF: result = {{16{is_signed & acc[15]}}, acc[15:0]};
      default:    result = acc;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Serialises 32/16/8-bit loads and stores onto an 8-bit synchronous RAM,
// one byte per cycle, big-endian, stalling the pipeline while it works.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              I_MA_CLK,
  input  logic              I_MA_RST,
  input  logic              I_MA_MemRead,
  input  logic              I_MA_MemWrite,
  input  logic [1:0]        I_MA_Trunk,
  input  logic              I_MA_signed,
  input  logic [31:0]       I_MA_ADDR,
  input  logic [31:0]       I_MA_WDATA,
  output logic [31:0]       O_MA_RDATA,
  output logic              O_MA_BUSY,
  output logic              O_MA_DONE,
  output logic [ADDR_W-1:0] O_MA_RAM_ADDR,
  output logic              O_MA_RAM_WE,
  output logic [7:0]        O_MA_RAM_WDATA,
  input  logic [7:0]        I_MA_RAM_RDATA
);

  ma_state_e          state;
  logic [1:0]         cnt;
  logic [ADDR_W-1:0]  base;
  logic [31:0]        wdata_q;
  logic [1:0]         trunk_q;
  logic               signed_q;
  logic               is_store;
  logic [31:0]        acc;
  logic [31:0]        rdata_q;
  logic               done_q;

  logic               req;
  logic [1:0]         last;
  logic [1:0]         byte_idx;
  logic [31:0]        acc_next;
  logic [31:0]        ext_result;

  logic unused_bits;
  assign unused_bits = &{1'b0, I_MA_ADDR[31:ADDR_W], acc[31:24]};

  assign req      = I_MA_MemRead | I_MA_MemWrite;
  assign last     = last_beat(trunk_q);
  assign byte_idx = last - cnt;
  // The final load byte arrives during TAIL, so extension works on the
  // accumulator with that byte already shifted in.
  assign acc_next = {acc[23:0], I_MA_RAM_RDATA};

  load_extender u_load_extender (
    .acc       (acc_next),
    .trunk     (trunk_q),
    .is_signed (signed_q),
    .result    (ext_result)
  );

  always_comb begin
    O_MA_RAM_ADDR  = '0;
    O_MA_RAM_WE    = 1'b0;
    O_MA_RAM_WDATA = 8'h00;
    if (state == XFER) begin
      O_MA_RAM_ADDR  = base + ADDR_W'(cnt);
      O_MA_RAM_WE    = is_store;
      O_MA_RAM_WDATA = wdata_q[{byte_idx, 3'b000} +: 8];
    end
  end

  // Stall is raised in the accept cycle itself so the pipeline freezes
  // before the request operands change.
  assign O_MA_BUSY = ~I_MA_RST &
                     (((state == IDLE) & req) | (state == XFER) | (state == TAIL));
  assign O_MA_DONE  = done_q;
  assign O_MA_RDATA = rdata_q;

  always_ff @(posedge I_MA_CLK or posedge I_MA_RST) begin
    if (I_MA_RST) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      base     <= '0;
      wdata_q  <= 32'h0;
      trunk_q  <= TRUNK_WORD;
      signed_q <= 1'b0;
      is_store <= 1'b0;
      acc      <= 32'h0;
      rdata_q  <= 32'h0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            base     <= I_MA_ADDR[ADDR_W-1:0];
            wdata_q  <= I_MA_WDATA;
            trunk_q  <= I_MA_Trunk;
            signed_q <= I_MA_signed;
            is_store <= I_MA_MemWrite;
            acc      <= 32'h0;
            cnt      <= 2'd0;
            state    <= XFER;
          end
        end
        XFER: begin
          // RAM data lags the address by one cycle, so beat k captures byte k-1.
          if (!is_store && cnt != 2'd0) begin
            acc <= acc_next;
          end
          if (cnt == last) begin
            cnt <= 2'd0;
            if (is_store) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= TAIL;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        TAIL: begin
          acc     <= acc_next;
          rdata_q <= ext_result;
          state   <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit against a byte RAM model
// with one-cycle read latency.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        trunk;
  logic              sgn;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  int                we_total;

  int                checks;
  int                errors;
  int                last_we;
  logic [31:0]       addr_log [4];

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .I_MA_CLK       (clk),
    .I_MA_RST       (rst),
    .I_MA_MemRead   (mem_read),
    .I_MA_MemWrite  (mem_write),
    .I_MA_Trunk     (trunk),
    .I_MA_signed    (sgn),
    .I_MA_ADDR      (addr),
    .I_MA_WDATA     (wdata),
    .O_MA_RDATA     (rdata),
    .O_MA_BUSY      (busy),
    .O_MA_DONE      (done),
    .O_MA_RAM_ADDR  (ram_addr),
    .O_MA_RAM_WE    (ram_we),
    .O_MA_RAM_WDATA (ram_wdata),
    .I_MA_RAM_RDATA (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM model: synchronous write, registered read, plus a preload port.
  initial we_total = 0;
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_total      <= we_total + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick;
    pl_en   = 1'b0;
  endtask

  // Issues one access from IDLE and follows it to DONE, checking stall,
  // latency, write pulses and the held load result.
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [1:0] tr, input logic sg,
                               input logic [31:0] a, input logic [31:0] wd,
                               input int n, input int exp_lat,
                               input logic [31:0] exp_rdata, input bit req_in_done);
    int lat;
    int busy_cnt;
    int we0;
    bit seen;
    we0       = we_total;
    mem_read  = rd;
    mem_write = wr;
    trunk     = tr;
    sgn       = sg;
    addr      = a;
    wdata     = wd;
    #1;
    checkOutput({tag, " accept busy"}, 32'(busy), 32'd1);
    busy_cnt  = busy ? 1 : 0;
    tick;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (c <= n) addr_log[c-1] = 32'(ram_addr);
      if (done) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        if (busy) busy_cnt++;
        tick;
      end
    end
    last_we = we_total - we0;
    checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    checkOutput({tag, " busy in done"}, 32'(busy), 32'd0);
    checkOutput({tag, " rdata"}, rdata, exp_rdata);
    if (req_in_done) begin
      mem_read = 1'b1;
      @(negedge clk);
      mem_read = 1'b0;
      tick;
      checkOutput({tag, " request in done ignored"}, 32'(busy), 32'd0);
      checkOutput({tag, " done single pulse"}, 32'(done), 32'd0);
    end else begin
      tick;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_we   = 0;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    trunk     = TRUNK_WORD;
    sgn       = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    pl_en     = 1'b0;
    pl_addr   = '0;
    pl_data   = 8'h00;

    tick;
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset ram_we", 32'(ram_we), 32'd0);
    checkOutput("reset ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("reset ram_wdata", 32'(ram_wdata), 32'h0);
    mem_read = 1'b1;
    #1;
    checkOutput("reset busy with request", 32'(busy), 32'd0);
    mem_read = 1'b0;

    preload(10'h010, 8'h80);
    preload(10'h011, 8'h12);
    preload(10'h012, 8'h34);
    preload(10'h013, 8'h56);
    preload(10'h3FE, 8'hA1);
    preload(10'h3FF, 8'hB2);
    preload(10'h000, 8'hC3);
    preload(10'h001, 8'hD4);
    preload(10'h022, 8'h5A);
    for (int i = 0; i < 4; i++) preload(10'(32'h30 + i), 8'hEE);
    rst = 1'b0;
    tick;

    applyStimulus("LW 0x10", 1, 0, TRUNK_WORD, 0, 32'h10, 32'h0, 4, 6, 32'h80123456, 0);
    checkOutput("LW beat0 addr", addr_log[0], 32'h010);
    checkOutput("LW beat3 addr", addr_log[3], 32'h013);
    checkOutput("LW no writes", 32'(last_we), 32'd0);

    applyStimulus("LB 0x10", 1, 0, TRUNK_BYTE, 1, 32'h10, 32'h0, 1, 3, 32'hFFFFFF80, 0);
    applyStimulus("LBU 0x10", 1, 0, TRUNK_BYTE, 0, 32'h10, 32'h0, 1, 3, 32'h00000080, 0);
    applyStimulus("LH 0x10", 1, 0, TRUNK_HALF, 1, 32'h10, 32'h0, 2, 4, 32'hFFFF8012, 0);
    applyStimulus("LHU 0x10", 1, 0, TRUNK_HALF, 0, 32'h10, 32'h0, 2, 4, 32'h00008012, 0);
    applyStimulus("LW code11 signed", 1, 0, 2'b11, 1, 32'h10, 32'h0, 4, 6, 32'h80123456, 1);

    applyStimulus("SH 0x20 rd+wr", 1, 1, TRUNK_HALF, 0, 32'h20, 32'hAABBCCDD, 2, 3, 32'h80123456, 0);
    checkOutput("SH we pulses", 32'(last_we), 32'd2);
    checkOutput("SH beat0 addr", addr_log[0], 32'h020);
    checkOutput("SH beat1 addr", addr_log[1], 32'h021);
    checkOutput("SH ram 0x20", 32'(mem[10'h020]), 32'h0CC);
    checkOutput("SH ram 0x21", 32'(mem[10'h021]), 32'h0DD);
    checkOutput("SH ram 0x22 untouched", 32'(mem[10'h022]), 32'h05A);

    applyStimulus("LW wrap 0x3FE", 1, 0, TRUNK_WORD, 0, 32'h3FE, 32'h0, 4, 6, 32'hA1B2C3D4, 0);
    checkOutput("wrap beat0 addr", addr_log[0], 32'h3FE);
    checkOutput("wrap beat1 addr", addr_log[1], 32'h3FF);
    checkOutput("wrap beat2 addr", addr_log[2], 32'h000);
    checkOutput("wrap beat3 addr", addr_log[3], 32'h001);

    applyStimulus("SB 0x13", 0, 1, TRUNK_BYTE, 0, 32'h13, 32'h12345678, 1, 2, 32'hA1B2C3D4, 0);
    checkOutput("SB we pulses", 32'(last_we), 32'd1);
    checkOutput("SB ram 0x13", 32'(mem[10'h013]), 32'h078);
    applyStimulus("LB 0x13 positive", 1, 0, TRUNK_BYTE, 1, 32'h13, 32'h0, 1, 3, 32'h00000078, 0);

    // Store aborted by reset while the third byte is being written.
    mem_write = 1'b1;
    trunk     = TRUNK_WORD;
    addr      = 32'h30;
    wdata     = 32'h11223344;
    tick;
    mem_write = 1'b0;
    tick;
    tick;
    checkOutput("SW beat2 we before reset", 32'(ram_we), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort ram_we", 32'(ram_we), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort ram_addr", 32'(ram_addr), 32'h0);
    checkOutput("abort rdata", rdata, 32'h0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    checkOutput("abort idle busy", 32'(busy), 32'd0);
    checkOutput("abort ram 0x30", 32'(mem[10'h030]), 32'h011);
    checkOutput("abort ram 0x31", 32'(mem[10'h031]), 32'h022);
    checkOutput("abort ram 0x32", 32'(mem[10'h032]), 32'h0EE);
    checkOutput("abort ram 0x33", 32'(mem[10'h033]), 32'h0EE);
    applyStimulus("LW 0x30 after abort", 1, 0, TRUNK_WORD, 0, 32'h30, 32'h0, 4, 6, 32'h1122EEEE, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
